// File: rtl/hslp_mul_pipe.sv
// Pipelined HSLP approximate multiplier: per-quadrant low-bit truncation, 3-stage
// valid/ready pipeline, per-result error flag and saturating error counter.
module hslp_mul_pipe #(
    parameter int WIDTH     = 8,
    parameter int TRUNC     = 2,
    parameter int ERR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [3:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     prod,
    output logic                   approx_err,
    input  logic                   err_clr,
    output logic [ERR_CNT_W-1:0]   err_cnt
);
    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam logic [WIDTH-1:0] TRUNC_MASK = ~((WIDTH'(1) << TRUNC) - WIDTH'(1));

    logic                 advance;
    logic                 s1_valid_reg;
    logic [WIDTH-1:0]     s1_a_reg;
    logic [WIDTH-1:0]     s1_b_reg;
    logic [3:0]           s1_mode_reg;
    logic                 s2_valid_reg;
    logic [PW-1:0]        s2_exact_reg;
    logic [WIDTH-1:0]     s2_q [4];
    logic                 out_valid_reg;
    logic [PW-1:0]        prod_reg;
    logic                 approx_err_reg;
    logic [PW-1:0]        prod_next;
    logic                 approx_err_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    // All stages move in lockstep; a stalled output freezes the whole pipe.
    assign advance  = !out_valid_reg || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_mode_reg  <= '0;
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            s1_a_reg     <= a;
            s1_b_reg     <= b;
            s1_mode_reg  <= mode;
        end
    end

    // Quadrant index gi: bit 1 selects the high half of a, bit 0 the high half of b.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_quad
            logic [HALF-1:0]  op_a;
            logic [HALF-1:0]  op_b;
            logic [WIDTH-1:0] q_exact;
            logic [WIDTH-1:0] q_appr;
            logic [WIDTH-1:0] q_reg;

            if (gi >= 2) begin : g_ah
                assign op_a = s1_a_reg[WIDTH-1:HALF];
            end else begin : g_al
                assign op_a = s1_a_reg[HALF-1:0];
            end
            if ((gi % 2) == 1) begin : g_bh
                assign op_b = s1_b_reg[WIDTH-1:HALF];
            end else begin : g_bl
                assign op_b = s1_b_reg[HALF-1:0];
            end

            assign q_exact = WIDTH'(op_a) * WIDTH'(op_b);
            assign q_appr  = s1_mode_reg[gi] ? (q_exact & TRUNC_MASK) : q_exact;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (advance) begin
                    q_reg <= q_appr;
                end
            end

            assign s2_q[gi] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_exact_reg <= '0;
        end else if (advance) begin
            s2_valid_reg <= s1_valid_reg;
            s2_exact_reg <= PW'(s1_a_reg) * PW'(s1_b_reg);
        end
    end

    always_comb begin
        prod_next       = {s2_q[3], WIDTH'(0)}
                        + ((PW'(s2_q[2]) + PW'(s2_q[1])) << HALF)
                        + PW'(s2_q[0]);
        approx_err_next = (prod_next != s2_exact_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            prod_reg       <= '0;
            approx_err_reg <= 1'b0;
        end else if (advance) begin
            out_valid_reg  <= s2_valid_reg;
            prod_reg       <= prod_next;
            approx_err_reg <= approx_err_next;
        end
    end

    // Clear wins over a simultaneous erroring handshake, which is then not counted.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt_reg <= '0;
        end else if (out_valid_reg && out_ready && approx_err_reg
                     && (err_cnt_reg != {ERR_CNT_W{1'b1}})) begin
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    assign out_valid  = out_valid_reg;
    assign prod       = prod_reg;
    assign approx_err = approx_err_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_hslp_mul_pipe.sv
// Self-checking bench for hslp_mul_pipe (WIDTH=8, TRUNC=2, ERR_CNT_W=2) with an
// arithmetic reference model and an in-order expected-result queue.
module tb_hslp_mul_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic        approx_err;
    logic        err_clr;
    logic [1:0]  err_cnt;

    hslp_mul_pipe #(.WIDTH(8), .TRUNC(2), .ERR_CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .prod       (prod),
        .approx_err (approx_err),
        .err_clr    (err_clr),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        e;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_err  = 0;
    logic        hold_pending = 1'b0;
    logic [15:0] held_prod;
    logic        held_err;
    logic        acc;
    logic        got;

    // Quadrant model: nibble products, truncation rounds down to a multiple of 4.
    function automatic logic [15:0] ref_prod(input int unsigned x, input int unsigned y,
                                             input int unsigned m);
        int unsigned q[4];
        q[0] = (x % 16) * (y % 16);
        q[1] = (x % 16) * (y / 16);
        q[2] = (x / 16) * (y % 16);
        q[3] = (x / 16) * (y / 16);
        for (int i = 0; i < 4; i++) begin
            if (((m >> i) & 1) == 1) q[i] = q[i] - (q[i] % 4);
        end
        return 16'(q[3] * 256 + (q[1] + q[2]) * 16 + q[0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at negedge, sample before the edge, check err_cnt after it.
    task automatic cycle(input logic v, input logic [7:0] ai, input logic [7:0] bi,
                         input logic [3:0] mi, input logic ordy, input logic clr,
                         output logic acc_o, output logic got_o);
        beat_t       e;
        logic [15:0] p;
        logic        err_hs;
        rst = 1'b0; in_valid = v; a = ai; b = bi; mode = mi;
        out_ready = ordy; err_clr = clr;
        #1;
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_prod", 32'(prod), 32'(held_prod));
            check("hold_err", 32'(approx_err), 32'(held_err));
        end
        acc_o  = in_valid && in_ready;
        got_o  = out_valid && out_ready;
        err_hs = 1'b0;
        if (got_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("prod", 32'(prod), 32'(e.p));
                check("approx_err", 32'(approx_err), 32'(e.e));
                err_hs = e.e;
                $display("out a=%02h b=%02h prod=%04h err=%b", e.a, e.b, prod, approx_err);
            end
        end
        if (acc_o) begin
            p = ref_prod(ai, bi, mi);
            exp_q.push_back('{ai, bi, p, (32'(p) != 32'(ai) * 32'(bi))});
        end
        if (clr) m_err = 0;
        else if (err_hs && m_err < 3) m_err++;
        hold_pending = out_valid && !out_ready;
        held_prod    = prod;
        held_err     = approx_err;
        @(posedge clk);
        @(negedge clk);
        check("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        a = '0; b = '0; mode = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_err = 0;
        hold_pending = 1'b0;
    endtask

    task automatic latency(input logic [7:0] ai, input logic [7:0] bi, input logic [3:0] mi,
                           input logic [15:0] ep, input logic ee);
        logic ac, gt;
        cycle(1'b1, ai, bi, mi, 1'b1, 1'b0, ac, gt);
        check("lat_acc", 32'(ac), 32'd1);
        check("lat_c1", 32'(out_valid), 32'd0);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, ac, gt);
        check("lat_c2", 32'(out_valid), 32'd0);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, ac, gt);
        check("lat_c3", 32'(out_valid), 32'd1);
        check("lat_prod", 32'(prod), 32'(ep));
        check("lat_err", 32'(approx_err), 32'(ee));
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, ac, gt);
        check("lat_got", 32'(gt), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rm;
        logic [7:0] bp_a[4];
        logic [7:0] bp_b[4];
        logic [3:0] bp_m[4];
        int         idx;
        int         k;
        int         sat_exp[5];

        sat_exp = '{1, 2, 3, 3, 3};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        a = '0; b = '0; mode = '0;
        @(negedge clk);
        do_reset();
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_prod", 32'(prod), 32'd0);
        check("rst_approx_err", 32'(approx_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed corner products with known constants.
        latency(8'hFF, 8'hFF, 4'h0, 16'hFE01, 1'b0);
        check("err_cnt_mode0", 32'(err_cnt), 32'd0);
        latency(8'hFF, 8'hFF, 4'hF, 16'hFCE0, 1'b1);
        check("err_cnt_modeF", 32'(err_cnt), 32'd1);
        latency(8'hFF, 8'hFF, 4'h1, 16'hFE00, 1'b1);
        check("err_cnt_mode1", 32'(err_cnt), 32'd2);

        // Random stream at full throughput.
        for (int i = 0; i < 13; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 4'($urandom_range(0, 15));
            cycle((i < 10), ra, rb, rm, 1'b1, 1'b0, acc, got);
            check("stream_slot", 32'(got), 32'((i >= 3) ? 1 : 0));
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: only the three stages fill, the fourth beat waits.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 8'($urandom_range(0, 255));
            bp_b[i] = 8'($urandom_range(0, 255));
            bp_m[i] = 4'($urandom_range(0, 15));
        end
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, bp_a[idx], bp_b[idx], bp_m[idx], 1'b0, 1'b0, acc, got);
            check("bp_accept", 32'(acc), 32'((i < 3) ? 1 : 0));
            if (acc && idx < 3) idx++;
        end
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_accepted", 32'(idx), 32'd3);
        for (int i = 0; i < 10; i++) begin
            if (idx < 4) begin
                cycle(1'b1, bp_a[idx], bp_b[idx], bp_m[idx], 1'b1, 1'b0, acc, got);
                if (acc) idx++;
            end else if (exp_q.size() != 0) begin
                cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, acc, got);
            end
        end
        check("bp_fourth_taken", 32'(idx), 32'd4);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Saturating error counter and clear priority.
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, acc, got);
        k = 0;
        for (int i = 0; i < 9; i++) begin
            cycle((i < 5), 8'hFF, 8'hFF, 4'hF, 1'b1, 1'b0, acc, got);
            if (got && k < 5) begin
                check("sat_seq", 32'(err_cnt), 32'(sat_exp[k]));
                k++;
            end
        end
        check("sat_count", 32'(k), 32'd5);
        cycle(1'b1, 8'hFF, 8'hFF, 4'hF, 1'b1, 1'b0, acc, got);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, acc, got);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, acc, got);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, acc, got);
        check("clr_hs", 32'(got), 32'd1);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);

        // Reset with two beats in flight, then fresh latency.
        cycle(1'b1, 8'hFF, 8'hFF, 4'hF, 1'b1, 1'b0, acc, got);
        cycle(1'b1, 8'h12, 8'h34, 4'h3, 1'b1, 1'b0, acc, got);
        do_reset();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, acc, got);
            check("midrst_no_out", 32'(got), 32'd0);
        end
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rm = 4'($urandom_range(0, 15));
        latency(ra, rb, rm, ref_prod(ra, rb, rm), (32'(ref_prod(ra, rb, rm)) != 32'(ra) * 32'(rb)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
